// File: rtl/sobel_mag.sv
// Sobel gradient magnitude stage: |gx|+|gy| saturated to 8 bits, border
// suppression, per-frame latched edge threshold and frame position flags.
// Two registered stages share one enable, so a stalled output freezes the
// whole pipeline.
module sobel_mag #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] gx_in,
    input  logic signed [15:0] gy_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         thresh,
    output logic [7:0]         mag_out,
    output logic               edge_out,
    output logic               sof_out,
    output logic               eol_out,
    output logic               eof_out,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int DATA_W = 16;
    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    // Absolute value widened by one bit so that -32768 maps to 32768.
    function automatic logic [DATA_W:0] abs_ext(input logic signed [DATA_W-1:0] v);
        logic signed [DATA_W:0] w;
        w = {v[DATA_W-1], v};
        if (w < 0) begin
            return unsigned'(-w);
        end
        return unsigned'(w);
    endfunction

    // Clamp the 18-bit magnitude sum to the 8-bit output range.
    function automatic logic [7:0] sat8(input logic [DATA_W+1:0] s);
        if (s > (DATA_W+2)'(255)) begin
            return 8'hFF;
        end
        return s[7:0];
    endfunction

    logic             en;
    logic             accept;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [7:0]       thr_lat;
    logic             first_px;
    logic             last_col;
    logic             last_row;
    logic             border;
    logic [7:0]       thr_eff;

    logic              vld_p1;
    logic [DATA_W:0]   abs_gx_p1;
    logic [DATA_W:0]   abs_gy_p1;
    logic [7:0]        thr_p1;
    logic              border_p1;
    logic              sof_p1;
    logic              eol_p1;
    logic              eof_p1;

    logic [DATA_W+1:0] sum_p1;
    logic [7:0]        mag_sat;
    logic [7:0]        mag_nxt;
    logic              edge_nxt;

    logic              vld_p2;
    logic [7:0]        mag_p2;
    logic              edge_p2;
    logic              sof_p2;
    logic              eol_p2;
    logic              eof_p2;

    assign en       = !vld_p2 || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    assign first_px = (col == '0) && (row == '0);
    assign last_col = (col == COL_W'(IMG_W - 1));
    assign last_row = (row == ROW_W'(IMG_H - 1));
    assign border   = (col == '0) || (row == '0) || last_col || last_row;
    // The frame's first pixel already uses the threshold it latches.
    assign thr_eff  = first_px ? thresh : thr_lat;

    // Pixel position counters and per-frame threshold, stepped on accepted beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col     <= '0;
            row     <= '0;
            thr_lat <= '0;
        end else if (accept) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
            if (first_px) begin
                thr_lat <= thresh;
            end
        end
    end

    // ---- stage p1: absolute values and position flags ----
    // Stage-1 valid advances whenever the pipeline is enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (en) begin
            vld_p1 <= in_valid;
        end
    end

    // Stage-1 data captured with each accepted beat.
    always_ff @(posedge clk) begin
        if (accept) begin
            abs_gx_p1 <= abs_ext(gx_in);
            abs_gy_p1 <= abs_ext(gy_in);
            thr_p1    <= thr_eff;
            border_p1 <= border;
            sof_p1    <= first_px;
            eol_p1    <= last_col;
            eof_p1    <= last_col && last_row;
        end
    end

    // Magnitude, saturation, border suppression and threshold compare.
    always_comb begin
        sum_p1   = {1'b0, abs_gx_p1} + {1'b0, abs_gy_p1};
        mag_sat  = sat8(sum_p1);
        mag_nxt  = border_p1 ? 8'd0 : mag_sat;
        edge_nxt = !border_p1 && (mag_sat >= thr_p1);
    end

    // ---- stage p2: registered outputs ----
    // Output register, held while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            mag_p2  <= '0;
            edge_p2 <= 1'b0;
            sof_p2  <= 1'b0;
            eol_p2  <= 1'b0;
            eof_p2  <= 1'b0;
        end else if (en) begin
            vld_p2  <= vld_p1;
            mag_p2  <= mag_nxt;
            edge_p2 <= edge_nxt;
            sof_p2  <= sof_p1;
            eol_p2  <= eol_p1;
            eof_p2  <= eof_p1;
        end
    end

    assign out_valid = vld_p2;
    assign mag_out   = mag_p2;
    assign edge_out  = edge_p2;
    assign sof_out   = sof_p2;
    assign eol_out   = eol_p2;
    assign eof_out   = eof_p2;

endmodule

// File: tb/tb_sobel_mag.sv
// Directed bench for sobel_mag on a 4x4 frame.
module tb_sobel_mag;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [15:0] gx_in = '0;
    logic signed [15:0] gy_in = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [7:0]         thresh = '0;
    logic [7:0]         mag_out;
    logic               edge_out;
    logic               sof_out;
    logic               eol_out;
    logic               eof_out;
    logic               out_valid;
    logic               out_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [12:0]        outq[$];
    logic signed [15:0] sgx[32];
    logic signed [15:0] sgy[32];
    logic [7:0]         sth[32];
    logic [7:0]         emag[32];
    logic               eedg[32];

    sobel_mag #(.IMG_W(4), .IMG_H(4)) dut (
        .clk(clk), .rst(rst), .gx_in(gx_in), .gy_in(gy_in),
        .in_valid(in_valid), .in_ready(in_ready), .thresh(thresh),
        .mag_out(mag_out), .edge_out(edge_out), .sof_out(sof_out),
        .eol_out(eol_out), .eof_out(eof_out), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Record each output beat that will transfer on the next rising edge.
    always @(negedge clk) begin
        if (out_valid && out_ready && !rst)
            outq.push_back({mag_out, edge_out, sof_out, eol_out, eof_out});
    end

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [2:0] pos_flags(input int i);
        return {(i % 16) == 0, (i % 4) == 3, (i % 16) == 15};
    endfunction

    task automatic clear_vec();
        for (int i = 0; i < 32; i++) begin
            sgx[i] = '0; sgy[i] = '0; sth[i] = 8'd60; emag[i] = '0; eedg[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        outq.delete();
    endtask

    task automatic push(input logic signed [15:0] gx, input logic signed [15:0] gy,
                        input logic [7:0] th);
        int n;
        bit acc;
        gx_in = gx; gy_in = gy; thresh = th; in_valid = 1'b1;
        n = 0; acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL push_accept got=not_accepted exp=accepted");
        end
    endtask

    task automatic send(input int base, input int n);
        for (int i = base; i < base + n; i++) push(sgx[i], sgy[i], sth[i]);
    endtask

    task automatic drain(input int n);
        int k;
        k = 0;
        while (outq.size() < n && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; #1; rst = 1'b1; #3;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (mag_out !== 8'd0) begin failures++; $display("FAIL reset_mag got=%0d exp=0", mag_out); end
        checks++; if ({edge_out, sof_out, eol_out, eof_out} !== 4'b0) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {edge_out, sof_out, eol_out, eof_out});
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_latency();
        do_reset();
        out_ready = 1'b1;
        push(16'sd0, 16'sd0, 8'd60);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL latency_early got=%b exp=0", out_valid); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL latency_valid got=%b exp=1", out_valid); end
        checks++; if (sof_out !== 1'b1) begin failures++; $display("FAIL latency_sof got=%b exp=1", sof_out); end
    endtask

    task automatic test_basic();
        logic [12:0] got, expv;
        do_reset();
        clear_vec();
        out_ready = 1'b1;
        sgx[4] = 16'sd1000; sgy[4] = 16'sd1000;
        sgx[5] = 16'sd30;   sgy[5] = -16'sd40;  emag[5] = 8'd70; eedg[5] = 1'b1;
        sgx[6] = 16'sd20;   sgy[6] = 16'sd40;   emag[6] = 8'd60; eedg[6] = 1'b1;
        sgx[7] = -16'sd500;
        sgx[9] = 16'sd59;                       emag[9] = 8'd59;
        sgy[10] = -16'sd61;                     emag[10] = 8'd61; eedg[10] = 1'b1;
        send(0, 16);
        drain(16);
        checks++; if (outq.size() != 16) begin failures++; $display("FAIL basic_count got=%0d exp=16", outq.size()); end
        for (int i = 0; i < 16 && outq.size() > 0; i++) begin
            got = outq.pop_front();
            expv = {emag[i], eedg[i], pos_flags(i)};
            checks++;
            if (got !== expv) begin failures++; $display("FAIL basic_beat%0d got=%h exp=%h", i, got, expv); end
        end
    endtask

    task automatic test_saturation();
        logic [12:0] got, expv;
        do_reset();
        clear_vec();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) sth[i] = 8'd255;
        sgx[0] = -16'sd32768; sgy[0] = -16'sd32768;
        sgx[5] = -16'sd32768; sgy[5] = -16'sd32768; emag[5] = 8'd255; eedg[5] = 1'b1;
        sgx[6] = 16'sd100;    sgy[6] = 16'sd155;    emag[6] = 8'd255; eedg[6] = 1'b1;
        sgx[9] = 16'sd100;    sgy[9] = 16'sd154;    emag[9] = 8'd254;
        sgx[10] = 16'sd32767; sgy[10] = -16'sd32768; emag[10] = 8'd255; eedg[10] = 1'b1;
        send(0, 16);
        drain(16);
        checks++; if (outq.size() != 16) begin failures++; $display("FAIL sat_count got=%0d exp=16", outq.size()); end
        for (int i = 0; i < 16 && outq.size() > 0; i++) begin
            got = outq.pop_front();
            expv = {emag[i], eedg[i], pos_flags(i)};
            checks++;
            if (got !== expv) begin failures++; $display("FAIL sat_beat%0d got=%h exp=%h", i, got, expv); end
        end
    endtask

    task automatic test_frame();
        logic [12:0] got, expv;
        do_reset();
        clear_vec();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin sgx[i] = 16'sd50; sgy[i] = 16'sd50; end
        emag[5] = 8'd100; emag[6] = 8'd100; emag[9] = 8'd100; emag[10] = 8'd100;
        eedg[5] = 1'b1;   eedg[6] = 1'b1;   eedg[9] = 1'b1;   eedg[10] = 1'b1;
        send(0, 17);
        drain(17);
        checks++; if (outq.size() != 17) begin failures++; $display("FAIL frame_count got=%0d exp=17", outq.size()); end
        for (int i = 0; i < 17 && outq.size() > 0; i++) begin
            got = outq.pop_front();
            expv = {emag[i], eedg[i], pos_flags(i)};
            checks++;
            if (got !== expv) begin failures++; $display("FAIL frame_beat%0d got=%h exp=%h", i, got, expv); end
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] got, expv;
        do_reset();
        clear_vec();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin sgx[i] = 16'(10 * i); sth[i] = 8'd0; end
        emag[5] = 8'd50; emag[6] = 8'd60; emag[9] = 8'd90; emag[10] = 8'd100;
        eedg[5] = 1'b1;  eedg[6] = 1'b1;  eedg[9] = 1'b1;  eedg[10] = 1'b1;
        fork
            send(0, 16);
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_out_valid got=%b exp=1", out_valid); end
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain(16);
        checks++; if (outq.size() != 16) begin failures++; $display("FAIL stall_count got=%0d exp=16", outq.size()); end
        for (int i = 0; i < 16 && outq.size() > 0; i++) begin
            got = outq.pop_front();
            expv = {emag[i], eedg[i], pos_flags(i)};
            checks++;
            if (got !== expv) begin failures++; $display("FAIL stall_beat%0d got=%h exp=%h", i, got, expv); end
        end
    endtask

    task automatic test_thresh();
        logic [12:0] got, expv;
        do_reset();
        clear_vec();
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) sth[i] = (i < 6) ? 8'd60 : 8'd200;
        for (int f = 0; f < 2; f++) begin
            sgx[16*f+5] = 16'sd70;  emag[16*f+5] = 8'd70;
            sgx[16*f+6] = 16'sd100; emag[16*f+6] = 8'd100;
            sgx[16*f+9] = 16'sd210; emag[16*f+9] = 8'd210;
            sgy[16*f+10] = -16'sd200; emag[16*f+10] = 8'd200;
        end
        eedg[5] = 1'b1; eedg[6] = 1'b1; eedg[9] = 1'b1; eedg[10] = 1'b1;
        eedg[25] = 1'b1; eedg[26] = 1'b1;
        send(0, 32);
        drain(32);
        checks++; if (outq.size() != 32) begin failures++; $display("FAIL thr_count got=%0d exp=32", outq.size()); end
        for (int i = 0; i < 32 && outq.size() > 0; i++) begin
            got = outq.pop_front();
            expv = {emag[i], eedg[i], pos_flags(i)};
            checks++;
            if (got !== expv) begin failures++; $display("FAIL thr_beat%0d got=%h exp=%h", i, got, expv); end
        end
    endtask

    task automatic test_reset_mid();
        logic [12:0] got;
        do_reset();
        clear_vec();
        out_ready = 1'b1;
        sgx[5] = 16'sd30; sgy[5] = -16'sd40;
        send(0, 6);
        @(posedge clk); #1;
        checks++; if (mag_out !== 8'd70) begin failures++; $display("FAIL rstmid_pre_mag got=%0d exp=70", mag_out); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
        checks++; if (mag_out !== 8'd0) begin failures++; $display("FAIL rstmid_mag got=%0d exp=0", mag_out); end
        checks++; if ({edge_out, sof_out, eol_out, eof_out} !== 4'b0) begin
            failures++; $display("FAIL rstmid_flags got=%b exp=0000", {edge_out, sof_out, eol_out, eof_out});
        end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        outq.delete();
        push(16'sd1000, 16'sd1000, 8'd60);
        drain(1);
        checks++; if (outq.size() != 1) begin failures++; $display("FAIL rstmid_count got=%0d exp=1", outq.size()); end
        if (outq.size() > 0) begin
            got = outq.pop_front();
            checks++;
            if (got !== 13'b00000000_0_100) begin failures++; $display("FAIL rstmid_sof_beat got=%h exp=%h", got, 13'b00000000_0_100); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_basic();
        test_saturation();
        test_frame();
        test_back_to_back();
        test_thresh();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
